// File: rtl/aes_pkg.sv
// Shared AES helpers for the decryption datapath: GF(2^8) constant
// multipliers used by InvMixColumns and the sequencer state encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x (i.e. 02) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column_seq_if.sv
// Stream interface of the InvMixColumns engine: input valid/ready,
// output valid/ready and the busy status flag.
interface inv_mix_column_seq_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  // Upstream/downstream side (source of blocks, sink of results).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/inv_mix_col_word.sv
// Combinational InvMixColumns on one 32-bit column; row 0 is the MSB byte.
module inv_mix_col_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] b0, b1, b2, b3;

  assign {b0, b1, b2, b3} = col;

  assign mixed = {
    gmul0e(b0) ^ gmul0b(b1) ^ gmul0d(b2) ^ gmul09(b3),
    gmul09(b0) ^ gmul0e(b1) ^ gmul0b(b2) ^ gmul0d(b3),
    gmul0d(b0) ^ gmul09(b1) ^ gmul0e(b2) ^ gmul0b(b3),
    gmul0b(b0) ^ gmul0d(b1) ^ gmul09(b2) ^ gmul0e(b3)
  };

endmodule

// File: rtl/inv_mix_column_seq.sv
// Iterative AES InvMixColumns engine. A captured state is transformed
// COLS_PER_CYCLE columns per clock and the result is held until taken.
//
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   BUSY  | transforming one column group per clock
//   DONE  | result valid, held until out_ready; may accept next block
module inv_mix_column_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_mix_column_seq_if.slave  bus
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  // 2-bit column counter: a step of 4 wraps to 0, which is intended.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_GRP = 2'(COLS_PER_CYCLE * (NCYC - 1));

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("inv_mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [1:0]       col_cnt_q;
  // Word 3 holds column 0 (bits 127:96), word 0 holds column 3.
  logic [3:0][31:0] work_q;
  logic [3:0][31:0] result_q;
  logic             accept;

  logic [1:0]       word_idx [COLS_PER_CYCLE];
  logic [31:0]      col_sel  [COLS_PER_CYCLE];
  logic [31:0]      col_mix  [COLS_PER_CYCLE];

  // Select the working columns of the current group.
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      word_idx[g] = 2'd3 - (col_cnt_q + 2'(g));
      col_sel[g]  = work_q[word_idx[g]];
    end
  end

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      inv_mix_col_word u_col (
        .col   (col_sel[g]),
        .mixed (col_mix[g])
      );
    end
  endgenerate

  // Handshake outputs and next-state decode.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    state_d       = state_q;
    unique case (state_q)
      IDLE: bus.in_ready = 1'b1;
      BUSY: bus.busy = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: ;
    endcase
    accept = bus.in_valid & bus.in_ready;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (col_cnt_q == LAST_GRP) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data = result_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Work capture, column counter and result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_q <= 2'd0;
      work_q    <= '0;
      result_q  <= '0;
    end else if (accept) begin
      work_q    <= bus.in_data;
      col_cnt_q <= 2'd0;
    end else if (state_q == BUSY) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        result_q[word_idx[g]] <= col_mix[g];
      end
      col_cnt_q <= col_cnt_q + STEP;
    end
  end

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Directed and round-trip bench for inv_mix_column_seq at 1, 2 and 4
// columns per cycle.
module tb_inv_mix_column_seq;

  localparam logic [127:0] VEC_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] C6      = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inv_mix_column_seq_if ifc1 ();
  inv_mix_column_seq_if ifc2 ();
  inv_mix_column_seq_if ifc4 ();

  inv_mix_column_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
  inv_mix_column_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));
  inv_mix_column_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used to build round-trip stimulus.
  function automatic logic [127:0] fmix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                           x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ifc1.in_ready && n < 40) begin tick(); n++; end
    if (n >= 40) chk({tag, "_ready_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ifc1.out_valid && n < 40) begin tick(); n++; end
  endtask

  // Offer one block to dut1, check latency and result.
  task automatic send1(input logic [127:0] d, input logic [127:0] exp,
                       input string tag, input bit scramble);
    int n;
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = d;
    wait_ready(tag);
    tick();
    ifc1.in_valid = 1'b0;
    ifc1.in_data  = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!ifc1.out_valid && n < 40) begin
      if (scramble && n < 2) begin
        ifc1.in_valid = ~ifc1.in_valid;
        ifc1.in_data  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        ifc1.in_valid = 1'b0;
      end
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'd4);
    chk({tag, "_data"}, ifc1.out_data, exp);
  endtask

  initial begin
    int n;
    logic [127:0] d, held;
    bit ok_data, ok_rdy, ok_vld;
    int extra;

    rst = 1'b1;
    ifc1.in_valid = 1'b0; ifc1.in_data = '0; ifc1.out_ready = 1'b1;
    ifc2.in_valid = 1'b0; ifc2.in_data = '0; ifc2.out_ready = 1'b1;
    ifc4.in_valid = 1'b0; ifc4.in_data = '0; ifc4.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 128'(ifc1.out_valid), 128'd0);
    chk("rst_out_data", ifc1.out_data, 128'd0);
    chk("rst_busy", 128'(ifc1.busy), 128'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 128'(ifc1.in_ready), 128'd1);

    // Wider configurations, spec vector only.
    ifc4.in_valid = 1'b1; ifc4.in_data = VEC_IN;
    ifc2.in_valid = 1'b1; ifc2.in_data = VEC_IN;
    chk("c4_in_ready", 128'(ifc4.in_ready), 128'd1);
    chk("c2_in_ready", 128'(ifc2.in_ready), 128'd1);
    tick();
    ifc4.in_valid = 1'b0; ifc4.in_data = '1;
    ifc2.in_valid = 1'b0; ifc2.in_data = '1;
    n = 0;
    while (!ifc4.out_valid && n < 40) begin tick(); n++; end
    chk("c4_lat", 128'(n), 128'd1);
    chk("c4_data", ifc4.out_data, VEC_OUT);
    while (!ifc2.out_valid && n < 40) begin tick(); n++; end
    chk("c2_lat", 128'(n), 128'd2);
    chk("c2_data", ifc2.out_data, VEC_OUT);

    // Spec vector and fixed points on the 1-column engine.
    send1(VEC_IN, VEC_OUT, "vec1", 1'b0);
    send1(128'd0, 128'd0, "zero", 1'b0);
    send1(C6, C6, "c6", 1'b0);

    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send1(fmix(d), d, $sformatf("rt%0d", i), 1'b0);
    end

    // Input disturbed during BUSY must not affect the result.
    send1(VEC_IN, VEC_OUT, "scr", 1'b1);
    extra = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (ifc1.out_valid || ifc1.busy) extra++;
      tick();
    end
    chk("scr_no_extra", 128'(extra), 128'd0);

    // Backpressure: hold the result for 10 cycles with the next block waiting.
    ifc1.out_ready = 1'b0;
    ifc1.in_valid  = 1'b1;
    ifc1.in_data   = VEC_IN;
    wait_ready("bp");
    tick();
    ifc1.in_valid = 1'b0;
    wait_valid(n);
    chk("bp_lat", 128'(n), 128'd4);
    held = ifc1.out_data;
    chk("bp_data", held, VEC_OUT);
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = C6;
    ok_data = 1'b1; ok_rdy = 1'b1; ok_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc1.out_data !== held) ok_data = 1'b0;
      if (ifc1.in_ready !== 1'b0) ok_rdy = 1'b0;
      if (ifc1.out_valid !== 1'b1) ok_vld = 1'b0;
    end
    chk("bp_hold_data", 128'(ok_data), 128'd1);
    chk("bp_hold_in_ready", 128'(ok_rdy), 128'd1);
    chk("bp_hold_valid", 128'(ok_vld), 128'd1);
    ifc1.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 128'(ifc1.in_ready), 128'd1);
    tick();
    ifc1.in_data = 128'd0;
    wait_valid(n);
    chk("b2b1_lat", 128'(n), 128'd4);
    chk("b2b1_data", ifc1.out_data, C6);
    tick();
    ifc1.in_valid = 1'b0;
    wait_valid(n);
    chk("b2b2_lat", 128'(n), 128'd4);
    chk("b2b2_data", ifc1.out_data, 128'd0);
    tick();

    // Reset two cycles into BUSY.
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = VEC_IN;
    wait_ready("rm");
    tick();
    ifc1.in_valid = 1'b0;
    tick();
    tick();
    chk("rm_pre_busy", 128'(ifc1.busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("rm_out_valid", 128'(ifc1.out_valid), 128'd0);
    chk("rm_out_data", ifc1.out_data, 128'd0);
    chk("rm_busy", 128'(ifc1.busy), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rm_in_ready", 128'(ifc1.in_ready), 128'd1);
    send1(VEC_IN, VEC_OUT, "rm_fresh", 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
